// File: rtl/deserializador_pkg.sv
// Shared definitions for the 8b/10b deserializer: symbol width, the two
// K28.5 comma encodings and the alignment FSM states.
package deserializador_pkg;

  localparam int unsigned SYM_W = 10;

  // K28.5 in both running disparities, bit 0 = first bit on the wire.
  localparam logic [SYM_W-1:0] COMMA_RDN = 10'h17C;
  localparam logic [SYM_W-1:0] COMMA_RDP = 10'h283;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/deserializador_detector_coma.sv
// detector_coma: combinational K28.5 comma match on a 10-bit window.
// Ports:
//   sym_i   [9:0]  candidate symbol window
//   comma_o        high when sym_i equals either K28.5 disparity
module detector_coma
  import deserializador_pkg::*;
(
  input  logic [SYM_W-1:0] sym_i,
  output logic             comma_o
);

  assign comma_o = (sym_i == COMMA_RDN) || (sym_i == COMMA_RDP);

endmodule

// File: rtl/deserializador.sv
// deserializador: serial-to-10b deserializer with K28.5 comma alignment.
// A word boundary is declared after COMMA_COUNT commas arrive on a 10-bit
// grid; once locked, every 10th bit delivers an aligned symbol.
// Ports:
//   clkRx          receiver clock (rising edge)
//   rst            asynchronous active-high reset
//   enb            shift enable; all state holds while low
//   dataSync       serial input, already synchronous to clkRx
//   dataOut [9:0]  last aligned symbol, bit 0 = first bit received
//   validOut       one-cycle pulse when dataOut is refreshed
//   aligned        high while locked
//   errCount [7:0] saturating count of lock losses
//                  (only with DESERIALIZADOR_ERRCNT_EN defined)
module deserializador
  import deserializador_pkg::*;
#(
  parameter int unsigned COMMA_COUNT = 4
)
(
  input  logic             clkRx,
  input  logic             rst,
  input  logic             enb,
  input  logic             dataSync,
  output logic [SYM_W-1:0] dataOut,
  output logic             validOut,
  output logic             aligned
`ifdef DESERIALIZADOR_ERRCNT_EN
  ,
  output logic [7:0]       errCount
`endif
);

  localparam int unsigned CNT_W = $clog2(COMMA_COUNT + 1);

  state_e           state_q, state_d;
  logic [SYM_W-1:0] win_q;
  logic [SYM_W-1:0] nextWin;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic [CNT_W-1:0] commaCnt_q, commaCnt_d;
  logic [CNT_W-1:0] commaInc;
  logic [SYM_W-1:0] dataOut_q, dataOut_d;
  logic             validOut_q, validOut_d;
  logic             isComma;
  logic             boundary;

  assign nextWin  = {dataSync, win_q[SYM_W-1:1]};
  assign boundary = (bitCnt_q == 4'd9);
  assign commaInc = commaCnt_q + 1'b1;

  detector_coma u_detector_coma (
    .sym_i   (nextWin),
    .comma_o (isComma)
  );

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = boundary ? '0 : bitCnt_q + 4'd1;
    commaCnt_d = commaCnt_q;
    dataOut_d  = dataOut_q;
    validOut_d = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (isComma) begin
          bitCnt_d   = '0;
          commaCnt_d = CNT_W'(1);
          state_d    = (COMMA_COUNT == 1) ? LOCKED : CONFIRM;
        end
      end
      CONFIRM: begin
        if (isComma) begin
          if (boundary) begin
            commaCnt_d = commaInc;
            if (commaInc == CNT_W'(COMMA_COUNT)) state_d = LOCKED;
          end else begin
            state_d    = SEARCH;
            commaCnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          dataOut_d  = nextWin;
          validOut_d = enb;
        end else if (isComma) begin
          state_d    = SEARCH;
          commaCnt_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // validOut is updated on every edge so it drops even while enb is low;
  // everything else only advances on enabled edges.
  always_ff @(posedge clkRx or posedge rst) begin
    if (rst) begin
      state_q    <= SEARCH;
      win_q      <= '0;
      bitCnt_q   <= '0;
      commaCnt_q <= '0;
      dataOut_q  <= '0;
      validOut_q <= 1'b0;
    end else begin
      validOut_q <= validOut_d;
      if (enb) begin
        state_q    <= state_d;
        win_q      <= nextWin;
        bitCnt_q   <= bitCnt_d;
        commaCnt_q <= commaCnt_d;
        dataOut_q  <= dataOut_d;
      end
    end
  end

  assign dataOut  = dataOut_q;
  assign validOut = validOut_q;
  assign aligned  = (state_q == LOCKED);

`ifdef DESERIALIZADOR_ERRCNT_EN
  logic [7:0] errCnt_q;

  always_ff @(posedge clkRx or posedge rst) begin
    if (rst) begin
      errCnt_q <= '0;
    end else if (enb && state_q == LOCKED && state_d == SEARCH && errCnt_q != '1) begin
      errCnt_q <= errCnt_q + 8'd1;
    end
  end

  assign errCount = errCnt_q;
`endif

endmodule

// File: tb/tb_deserializador.sv
// Self-checking bench for deserializador: directed alignment scenarios with
// literal expectations plus a randomized stream, all checked every cycle
// against a behavioural model of the alignment rules.
module tb_deserializador;

  localparam int unsigned CC = 4;

  logic       clkRx    = 1'b0;
  logic       rst      = 1'b0;
  logic       enb      = 1'b0;
  logic       dataSync = 1'b0;
  logic [9:0] dataOut;
  logic       validOut;
  logic       aligned;
`ifdef DESERIALIZADOR_ERRCNT_EN
  logic [7:0] errCount;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned pulses = 0;

  always #5 clkRx = ~clkRx;

  deserializador #(.COMMA_COUNT(CC)) dut (
    .clkRx    (clkRx),
    .rst      (rst),
    .enb      (enb),
    .dataSync (dataSync),
    .dataOut  (dataOut),
    .validOut (validOut),
    .aligned  (aligned)
`ifdef DESERIALIZADOR_ERRCNT_EN
    ,
    .errCount (errCount)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_hist: last ten bits seen, newest in bit 9.
  // m_mode: 0 = hunting, 1..CC-1 = commas seen on a common grid, CC = locked.
  // m_since: enabled bits since the anchoring comma.
  logic [9:0]  m_hist, m_data;
  logic        m_valid;
  int unsigned m_mode, m_since, m_err;

  task automatic m_reset();
    m_hist  = '0;
    m_data  = '0;
    m_valid = 1'b0;
    m_mode  = 0;
    m_since = 0;
    m_err   = 0;
  endtask

  task automatic m_step(input logic b, input logic en);
    logic [9:0] w;
    logic       comma;
    logic       on_grid;
    m_valid = 1'b0;
    if (en) begin
      w       = {b, m_hist[9:1]};
      comma   = (w == 10'h17C) || (w == 10'h283);
      on_grid = ((m_since + 1) % 10) == 0;
      if (m_mode == 0) begin
        if (comma) begin
          m_mode  = 1;
          m_since = 0;
        end else begin
          m_since++;
        end
      end else if (m_mode < CC) begin
        m_since++;
        if (comma) m_mode = on_grid ? m_mode + 1 : 0;
      end else begin
        m_since++;
        if (on_grid) begin
          m_data  = w;
          m_valid = 1'b1;
        end else if (comma) begin
          m_mode = 0;
          if (m_err < 255) m_err++;
        end
      end
      m_hist = w;
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    m_reset();
    forever begin
      @(posedge clkRx or posedge rst);
      if (rst) m_reset();
      else     m_step(dataSync, enb);
      #1;
      check("aligned", 32'(aligned), 32'(m_mode == CC));
      check("validOut", 32'(validOut), 32'(m_valid));
      check("dataOut", 32'(dataOut), 32'(m_data));
`ifdef DESERIALIZADOR_ERRCNT_EN
      check("errCount", 32'(errCount), m_err);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_bit(input logic b);
    @(negedge clkRx);
    dataSync = b;
    enb      = 1'b1;
    @(posedge clkRx);
    #2;
    if (validOut) pulses++;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clkRx);
      enb      = 1'b0;
      dataSync = 1'($urandom_range(0, 1));
      @(posedge clkRx);
      #2;
      if (validOut) pulses++;
    end
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i]);
  endtask

  task automatic do_reset();
    @(negedge clkRx);
    rst = 1'b1;
    enb = 1'b0;
    repeat (3) @(negedge clkRx);
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] w;
    int unsigned r;

    #2 rst = 1'b1;
    repeat (3) @(negedge clkRx);
    check("rst_dataOut", 32'(dataOut), 32'h0);
    check("rst_validOut", 32'(validOut), 32'h0);
    check("rst_aligned", 32'(aligned), 32'h0);
    rst = 1'b0;

    // Idle zero stream never aligns.
    pulses = 0;
    repeat (200) send_bit(1'b0);
    check("zeros_pulses", pulses, 32'h0);
    check("zeros_aligned", 32'(aligned), 32'h0);
    check("zeros_dataOut", 32'(dataOut), 32'h0);

    // Offset stream, four commas lock, fifth is the first delivered word.
    repeat (3) send_bit(1'b0);
    pulses = 0;
    for (int k = 0; k < 3; k++) send_word(10'h17C);
    check("not_locked_after3", 32'(aligned), 32'h0);
    send_word(10'h17C);
    check("locked_after4", 32'(aligned), 32'h1);
    check("no_pulse_while_locking", pulses, 32'h0);
    send_word(10'h17C);
    check("first_pulse_valid", 32'(validOut), 32'h1);
    check("first_pulse_data", 32'(dataOut), 32'h17C);
    send_word(10'h0B5);
    check("data_pulse_valid", 32'(validOut), 32'h1);
    check("data_pulse_data", 32'(dataOut), 32'h0B5);
    check("pulse_count", pulses, 32'h2);

    // One slipped bit: the boundary now falls inside the comma word.
    send_bit(1'b0);
    pulses = 0;
    send_word(10'h17C);
    check("slip_aligned", 32'(aligned), 32'h0);
    check("slip_no_pulse_on_comma", 32'(validOut), 32'h0);
    check("slip_stale_boundary_pulses", pulses, 32'h1);
`ifdef DESERIALIZADOR_ERRCNT_EN
    check("slip_errCount", 32'(errCount), 32'h1);
`endif

    // Relock, then stall enb mid-word.
    for (int k = 0; k < 4; k++) send_word(10'h283);
    check("relock", 32'(aligned), 32'h1);
    pulses = 0;
    w = 10'h2A5;
    for (int i = 0; i < 4; i++) send_bit(w[i]);
    idle(7);
    check("stall_no_pulse", pulses, 32'h0);
    check("stall_aligned", 32'(aligned), 32'h1);
    for (int i = 4; i < 10; i++) send_bit(w[i]);
    check("stall_word_valid", 32'(validOut), 32'h1);
    check("stall_word_data", 32'(dataOut), 32'h2A5);
    check("stall_pulse_count", pulses, 32'h1);

    // Asynchronous reset between edges while locked and mid-word.
    w = 10'h155;
    for (int i = 0; i < 3; i++) send_bit(w[i]);
    @(posedge clkRx);
    #3 rst = 1'b1;
    #1;
    check("async_rst_dataOut", 32'(dataOut), 32'h0);
    check("async_rst_validOut", 32'(validOut), 32'h0);
    check("async_rst_aligned", 32'(aligned), 32'h0);
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) send_word(10'h17C);
    check("post_rst_not_locked_after3", 32'(aligned), 32'h0);
    send_word(10'h17C);
    check("post_rst_locked_after4", 32'(aligned), 32'h1);

    // Alternating disparity commas.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      send_word(10'h17C);
      send_word(10'h283);
    end
    check("alt_locked", 32'(aligned), 32'h1);
    send_word(10'h17C);
    check("alt_rdn_valid", 32'(validOut), 32'h1);
    check("alt_rdn_data", 32'(dataOut), 32'h17C);
    send_word(10'h283);
    check("alt_rdp_valid", 32'(validOut), 32'h1);
    check("alt_rdp_data", 32'(dataOut), 32'h283);

    // Randomized stream: commas, data, slips and enable gaps.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      send_word($urandom_range(0, 1) != 0 ? 10'h17C : 10'h283);
      else if (r == 3) send_bit(1'($urandom_range(0, 1)));
      else if (r == 4) idle($urandom_range(1, 5));
      else             send_word(10'($urandom));
    end

    @(negedge clkRx);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
